// File: rtl/alu.sv
// Single-cycle 32-bit ALU for the execute stage: result and Z/N/V flags
// are computed combinationally and registered together every rising edge.
module alu (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  ALUOP,
  input  logic [31:0] Port_A,
  input  logic [31:0] Port_B,
  output logic [31:0] output_port,
  output logic        negative,
  output logic        overflow,
  output logic        zero
);

  // Opcode encodings shared with cpu_types_pkg::aluop_t
  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SRL  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;

  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] result;
  logic        ovf;
  logic        lt_signed;
  logic        lt_unsigned;

  assign sum  = Port_A + Port_B;
  assign diff = Port_A - Port_B;

  // Differing operand signs decide the signed compare directly, so a
  // wrapped subtraction never corrupts SLT.
  assign lt_signed   = (Port_A[31] != Port_B[31]) ? Port_A[31] : diff[31];
  assign lt_unsigned = (Port_A < Port_B);

  always_comb begin
    result = 32'd0;
    ovf    = 1'b0;
    case (ALUOP)
      ALU_SLL:  result = Port_A << Port_B[4:0];
      ALU_SRL:  result = Port_A >> Port_B[4:0];
      ALU_ADD: begin
        result = sum;
        ovf    = (Port_A[31] == Port_B[31]) && (sum[31] != Port_A[31]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (Port_A[31] != Port_B[31]) && (diff[31] != Port_A[31]);
      end
      ALU_AND:  result = Port_A & Port_B;
      ALU_OR:   result = Port_A | Port_B;
      ALU_XOR:  result = Port_A ^ Port_B;
      ALU_NOR:  result = ~(Port_A | Port_B);
      ALU_SLT:  result = {31'd0, lt_signed};
      ALU_SLTU: result = {31'd0, lt_unsigned};
      default: begin
        result = 32'd0;
        ovf    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      output_port <= 32'd0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
    end else begin
      output_port <= result;
      negative    <= result[31];
      overflow    <= ovf;
      zero        <= (result == 32'd0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: each vector carries a hand-computed
// result and N/V/Z flags, plus edge-timing and asynchronous reset checks.
module tb_alu;

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRL  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_BAD  = 4'b1000;

  logic        CLK;
  logic        nRST;
  logic [3:0]  ALUOP;
  logic [31:0] Port_A;
  logic [31:0] Port_B;
  logic [31:0] output_port;
  logic        negative;
  logic        overflow;
  logic        zero;

  int numCompared;
  int numMismatched;

  alu dut (
    .CLK(CLK),
    .nRST(nRST),
    .ALUOP(ALUOP),
    .Port_A(Port_A),
    .Port_B(Port_B),
    .output_port(output_port),
    .negative(negative),
    .overflow(overflow),
    .zero(zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed/expected are packed as {result, N, V, Z}.
  task automatic checkOutput(input string tag, input logic [34:0] observed,
                             input logic [34:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got res=%h N=%b V=%b Z=%b, expected res=%h N=%b V=%b Z=%b",
               tag, observed[34:3], observed[2], observed[1], observed[0],
               expected[34:3], expected[2], expected[1], expected[0]);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge CLK);
    ALUOP  = op;
    Port_A = a;
    Port_B = b;
  endtask

  task automatic runVector(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic n,
                           input logic v, input logic z);
    applyStimulus(op, a, b);
    @(posedge CLK);
    #1;
    checkOutput(tag, {output_port, negative, overflow, zero}, {res, n, v, z});
  endtask

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    nRST   = 1'b0;
    ALUOP  = OP_ADD;
    Port_A = 32'd1;
    Port_B = 32'd1;
    #1;
    checkOutput("reset_initial", {output_port, negative, overflow, zero}, 35'd0);

    @(negedge CLK);
    nRST = 1'b1;

    runVector("and_1_1",     OP_AND, 32'h1, 32'h1, 32'h1, 0, 0, 0);
    runVector("and_1_0",     OP_AND, 32'h1, 32'h0, 32'h0, 0, 0, 1);
    runVector("and_pattern", OP_AND, 32'hABABABAB, 32'hBABABABA, 32'hAAAAAAAA, 1, 0, 0);
    runVector("or_all_ones", OP_OR,  32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1, 0, 0);
    runVector("or_low",      OP_OR,  32'hAAAAAA00, 32'h0000000F, 32'hAAAAAA0F, 1, 0, 0);
    runVector("add_1_1",     OP_ADD, 32'd1, 32'd1, 32'd2, 0, 0, 0);
    runVector("add_10_10",   OP_ADD, 32'd10, 32'd10, 32'd20, 0, 0, 0);
    runVector("add_m5_10",   OP_ADD, 32'hFFFFFFFB, 32'd10, 32'd5, 0, 0, 0);
    runVector("add_m10_10",  OP_ADD, 32'hFFFFFFF6, 32'd10, 32'd0, 0, 0, 1);
    runVector("add_pos_ovf", OP_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 1, 0);
    runVector("add_neg_ovf", OP_ADD, 32'h80000000, 32'h80000000, 32'h0, 0, 1, 1);
    runVector("sub_15_10",   OP_SUB, 32'd15, 32'd10, 32'd5, 0, 0, 0);
    runVector("sub_10_15",   OP_SUB, 32'd10, 32'd15, 32'hFFFFFFFB, 1, 0, 0);
    runVector("sub_min_1",   OP_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, 0);
    runVector("sub_max_m1",  OP_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 1, 0);
    runVector("sll_5",       OP_SLL, 32'd1, 32'd5, 32'h00000020, 0, 0, 0);
    runVector("sll_b25",     OP_SLL, 32'd1, 32'h25, 32'h00000020, 0, 0, 0);
    runVector("srl_31",      OP_SRL, 32'h80000000, 32'd31, 32'd1, 0, 0, 0);
    runVector("srl_4",       OP_SRL, 32'hFFFFFFFF, 32'd4, 32'h0FFFFFFF, 0, 0, 0);
    runVector("slt_m1_1",    OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0);
    runVector("sltu_big_1",  OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 1);
    runVector("sltu_1_big",  OP_SLTU, 32'd1, 32'hFFFFFFFF, 32'd1, 0, 0, 0);
    runVector("slt_min_max", OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1, 0, 0, 0);
    runVector("slt_max_min", OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'd0, 0, 0, 1);
    runVector("xor_equal",   OP_XOR, 32'h12345678, 32'h12345678, 32'd0, 0, 0, 1);
    runVector("nor_zero",    OP_NOR, 32'd0, 32'd0, 32'hFFFFFFFF, 1, 0, 0);
    runVector("bad_opcode",  OP_BAD, 32'h7FFFFFFF, 32'd1, 32'd0, 0, 0, 1);

    // Outputs must hold until the next rising edge after inputs change.
    runVector("timing_first", OP_ADD, 32'd1, 32'd1, 32'd2, 0, 0, 0);
    applyStimulus(OP_ADD, 32'd3, 32'd4);
    #2;
    checkOutput("timing_hold", {output_port, negative, overflow, zero}, {32'd2, 3'b000});
    @(posedge CLK);
    #1;
    checkOutput("timing_update", {output_port, negative, overflow, zero}, {32'd7, 3'b000});

    // Reset mid-stream clears outputs without waiting for a clock edge.
    #1;
    nRST = 1'b0;
    #1;
    checkOutput("reset_async", {output_port, negative, overflow, zero}, 35'd0);
    @(posedge CLK);
    #1;
    checkOutput("reset_held", {output_port, negative, overflow, zero}, 35'd0);

    applyStimulus(OP_SUB, 32'd15, 32'd10);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("reset_release", {output_port, negative, overflow, zero}, {32'd5, 3'b000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Single-cycle 32-bit arithmetic/logic unit for the processor datapath's execute stage. It takes two 32-bit operands and an `aluop_t` opcode from `cpu_types_pkg`, computes the result plus zero/negative/overflow flags, and presents all four on registered outputs one clock after the operands are applied.

## Interface
Parameters:
- none (datapath width fixed at 32 bits)

Ports:
- `CLK` input, 1 bit: rising-edge clock. This is the block's only clock.
- `nRST` input, 1 bit: reset, asynchronous and active-low.
- `ALUOP` input, `aluop_t` (4 bits): operation select.
- `Port_A` input, 32 bits: operand A. It is the value shifted for shift operations.
- `Port_B` input, 32 bits: operand B. Bits [4:0] give the shift amount for shift operations.
- `output_port` output, 32 bits: registered result.
- `negative` output, 1 bit: registered copy of result bit 31.
- `overflow` output, 1 bit: registered signed-overflow flag.
- `zero` output, 1 bit: registered flag, 1 when the result equals 0.

## Operation
Opcode encodings follow `cpu_types_pkg`:
- ALU_SLL, 4'b0000: result = A << B[4:0]. Zeros are shifted in.
- ALU_SRL, 4'b0001: result = A >> B[4:0]. Logical shift, zeros are shifted in.
- ALU_ADD, 4'b0010: result = A + B, modulo 2^32.
- ALU_SUB, 4'b0011: result = A − B, modulo 2^32.
- ALU_AND, 4'b0100: result = A & B.
- ALU_OR, 4'b0101: result = A | B.
- ALU_XOR, 4'b0110: result = A ^ B.
- ALU_NOR, 4'b0111: result = ~(A | B).
- ALU_SLT, 4'b1010: result = 32'd1 if $signed(A) < $signed(B), else 0.
- ALU_SLTU, 4'b1011: result = 32'd1 if A < B unsigned, else 0.
- Any other encoding: result = 0, overflow = 0.

Flags:
- overflow, ADD: 1 when A[31] == B[31] and result[31] != A[31].
- overflow, SUB: 1 when A[31] != B[31] and result[31] != A[31].
- overflow: 0 for every other operation.
- SLT must not use the truncated subtraction sign alone. It must produce the correct signed compare even when A − B overflows.
- negative = result[31], for all operations.
- zero = (result == 0), for all operations.
- The carry-out of ADD/SUB is discarded and is not reported.

## Timing
- Result and flags are computed combinationally from ALUOP, Port_A and Port_B.
- All four outputs are captured together on each rising CLK edge. Latency is exactly 1 cycle, and a new operation can be accepted every cycle.
- There is no handshake and no enable. The unit registers its inputs every cycle.
- Reset: when nRST is low, output_port = 0, negative = 0, overflow = 0 and zero = 0. This applies immediately, without waiting for CLK, and holds while nRST is low.
- The first rising edge after nRST deasserts registers the current inputs normally.
- If reset asserts mid-operation, the in-flight result is lost and the outputs take their reset values.
- Inputs that change between edges have no effect on the outputs until the next rising edge.

## Test plan
1. AND and OR:
   - AND 1 & 1 -> 1.
   - AND 1 & 0 -> 0, zero = 1.
   - AND 0xABABABAB & 0xBABABABA -> 0xAAAAAAAA.
   - OR 0x55555555 | 0xAAAAAAAA -> 0xFFFFFFFF, negative = 1.
   - OR 0xAAAAAA00 | 0x0000000F -> 0xAAAAAA0F.
2. ADD:
   - 1 + 1 -> 2 (V = 0, N = 0, Z = 0).
   - 10 + 10 -> 20.
   - −5 + 10 -> 5.
   - −10 + 10 -> 0 with zero = 1.
   - 0x7FFFFFFF + 1 -> 0x80000000 with overflow = 1 and negative = 1.
3. SUB:
   - 15 − 10 -> 5.
   - 10 − 15 -> 0xFFFFFFFB with negative = 1 and overflow = 0.
   - 0x80000000 − 1 -> 0x7FFFFFFF with overflow = 1.
4. Shifts:
   - SLL 1 by 5 -> 0x00000020.
   - SLL 1 by B = 0x25 -> 0x00000020, since only B[4:0] is used.
   - SRL 0x80000000 by 31 -> 1.
5. Compares:
   - SLT −1 < 1 -> 1.
   - SLTU 0xFFFFFFFF < 1 -> 0.
   - SLT 0x80000000 < 0x7FFFFFFF -> 1 (the subtraction overflows).
   - XOR of equal operands -> 0, zero = 1.
   - NOR 0 with 0 -> 0xFFFFFFFF.
6. Timing and reset:
   - Check that outputs update only on the rising edge after the inputs change.
   - Assert nRST mid-stream with a nonzero result held: all outputs go to 0 immediately, before the next CLK edge.
   - After release, the first edge returns the correct result for the current inputs.
